// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
// Holds the FSM state enum, wait-counter width and response encodings.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam int CNT_W = 4;

    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_SLVERR = 1'b1;

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: strobe-masked write, read mux,
// constant register 0 (ID) and flattened contents.
// Ports: clk/resetn, write enable/index/data/strobe, read index/data,
// o_regs_q = all registers, register i at [i*DATA_W +: DATA_W].
module apb_reg_bank #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 16,
    parameter int          IDX_W    = 4,
    parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_we,
    input  logic [IDX_W-1:0]           i_widx,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [DATA_W/8-1:0]        i_strb,
    input  logic [IDX_W-1:0]           i_ridx,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_W-1:0] o_regs_q
);

    localparam int BYTES = DATA_W / 8;

    logic [NUM_REGS*DATA_W-1:0] w_flat;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == 0) begin : g_id
            // Register 0 is a read-only identification constant.
            assign w_flat[0 +: DATA_W] = ID_VALUE[DATA_W-1:0];
        end else begin : g_rw
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_q <= '0;
                end else if (i_we && (i_widx == IDX_W'(gi))) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (i_strb[k]) begin
                            r_q[k*8 +: 8] <= i_wdata[k*8 +: 8];
                        end
                    end
                end
            end

            assign w_flat[gi*DATA_W +: DATA_W] = r_q;
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_ridx == IDX_W'(i)) begin
                o_rdata = w_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_regs_q = w_flat;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer with a register bank, programmable wait states, byte
// strobes, PSLVERR and a sticky protocol-violation flag.
// Ports: APB bus (paddr..pslverr), wait_cfg, proto_err/proto_clr, regs_q.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic                       pwrite,
    input  logic                       psel,
    input  logic                       penable,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [DATA_W/8-1:0]        pstrb,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    input  logic [CNT_W-1:0]           wait_cfg,
    output logic                       proto_err,
    input  logic                       proto_clr,
    output logic [NUM_REGS*DATA_W-1:0] regs_q
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    apb_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [BYTES-1:0]    r_strb;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_pready;
    logic                r_pslverr;
    logic                r_proto_err;

    logic [ADDR_W-1:0]   w_src_addr;
    logic                w_src_write;
    logic [ADDR_W-1:0]   w_word;
    logic [IDX_W-1:0]    w_idx;
    logic                w_err;
    logic                w_we;
    logic                w_active;
    logic                w_proto_set;
    logic [DATA_W-1:0]   w_bank_rdata;
    logic [DATA_W-1:0]   w_resp_data;

    // With zero wait states the response is built at the setup edge,
    // so decode looks at the live bus in IDLE and the latch otherwise.
    assign w_src_addr  = (r_state == IDLE) ? paddr  : r_addr;
    assign w_src_write = (r_state == IDLE) ? pwrite : r_write;

    assign w_word = w_src_addr >> OFF_W;
    assign w_idx  = w_word[IDX_W-1:0];

    assign w_err = (|(w_src_addr & OFF_MASK))
                 || (32'(w_word) >= 32'(NUM_REGS))
                 || (w_src_write && (w_word == '0));

    assign w_resp_data = (w_err || w_src_write) ? '0 : w_bank_rdata;

    assign w_active = psel && penable;

    assign w_we = (r_state == ACCESS) && w_active
               && (r_cnt == '0) && r_write && !w_err;

    assign w_proto_set = (r_state == IDLE)
                       ? (psel && penable)
                       : !w_active;

    apb_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk      (clk),
        .resetn   (resetn),
        .i_we     (w_we),
        .i_widx   (w_idx),
        .i_wdata  (r_wdata),
        .i_strb   (r_strb),
        .i_ridx   (w_idx),
        .o_rdata  (w_bank_rdata),
        .o_regs_q (regs_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_prdata    <= '0;
            r_pready    <= 1'b0;
            r_pslverr   <= APB_OKAY;
            r_proto_err <= 1'b0;
        end else begin
            if (proto_clr) begin
                r_proto_err <= 1'b0;
            end else if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (psel && !penable) begin
                        r_state <= ACCESS;
                        r_cnt   <= wait_cfg;
                        r_addr  <= paddr;
                        r_write <= pwrite;
                        r_wdata <= pwdata;
                        r_strb  <= pstrb;
                        if (wait_cfg == '0) begin
                            r_pready  <= 1'b1;
                            r_prdata  <= w_resp_data;
                            r_pslverr <= w_err ? APB_SLVERR : APB_OKAY;
                        end
                    end
                end
                ACCESS: begin
                    if (w_active) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                            // Response is presented as the count hits 0.
                            if (r_cnt == CNT_W'(1)) begin
                                r_pready  <= 1'b1;
                                r_prdata  <= w_resp_data;
                                r_pslverr <= w_err ? APB_SLVERR : APB_OKAY;
                            end
                        end else begin
                            r_state   <= IDLE;
                            r_pready  <= 1'b0;
                            r_prdata  <= '0;
                            r_pslverr <= APB_OKAY;
                        end
                    end else begin
                        // Master withdrew mid-transfer: drop it silently.
                        r_state   <= IDLE;
                        r_pready  <= 1'b0;
                        r_prdata  <= '0;
                        r_pslverr <= APB_OKAY;
                    end
                end
            endcase
        end
    end

    assign prdata    = r_prdata;
    assign pready    = r_pready;
    assign pslverr   = r_pslverr;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave (default parameters).
// Expected responses are queued at stimulus time and matched on pready.
module tb_apb_regfile_slave;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [7:0]   paddr = '0;
    logic         pwrite = 1'b0;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [3:0]   wait_cfg = '0;
    logic         proto_err;
    logic         proto_clr = 1'b0;
    logic [511:0] regs_q;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        chk;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       obs_q[$];
    logic [31:0] mem [16];
    int          checks = 0;
    int          failures = 0;

    apb_regfile_slave dut (
        .clk       (clk),
        .resetn    (resetn),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .wait_cfg  (wait_cfg),
        .proto_err (proto_err),
        .proto_clr (proto_clr),
        .regs_q    (regs_q)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && pready) begin
            obs_q.push_back('{data: prdata, err: pslverr, chk: 1'b1});
        end
    end

    function automatic logic [31:0] reg_at(input int i);
        return regs_q[i*32 +: 32];
    endfunction

    function automatic void model_wr(input int idx, input logic [31:0] d,
                                     input logic [3:0] s);
        for (int k = 0; k < 4; k++) begin
            if (s[k]) mem[idx][k*8 +: 8] = d[k*8 +: 8];
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left at #1 after a rising edge, so calls chain back-to-back.
    task automatic apb_xfer(input logic [7:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] s,
                            output int cycles);
        psel = 1'b1;
        penable = 1'b0;
        paddr = a;
        pwrite = w;
        pwdata = d;
        pstrb = s;
        @(posedge clk);
        #1;
        penable = 1'b1;
        paddr = 8'hFF;
        pwdata = 32'hDEAD_BEEF;
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (pready || cycles > 40) break;
        end
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset;
        int cyc;
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b err=%b data=%h, want 0/0/0",
                     pready, pslverr, prdata);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_proto: got %b want 0", proto_err);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (reg_at(i) !== mem[i]) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h want %h", i, reg_at(i), mem[i]);
            end
        end
        wait_cfg = 4'd0;
        exp_q.push_back('{data: ID, err: 1'b0, chk: 1'b1});
        apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, cyc);
        checks++;
        if (cyc !== 1) begin
            failures++;
            $display("FAIL reset_id_latency: got %0d want 1", cyc);
        end
        while (exp_q.size() > 0) begin
            resp_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL reset_id_resp: got none want data=%h err=%b",
                         e.data, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || (e.chk && o.data !== e.data)) begin
                    failures++;
                    $display("FAIL reset_id_resp: got %h/%b want %h/%b",
                             o.data, o.err, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_zero_wait;
        int cyc;
        wait_cfg = 4'd0;
        exp_q.push_back('{data: 32'h0, err: 1'b0, chk: 1'b0});
        apb_xfer(8'h04, 1'b1, 32'h1234_5678, 4'hF, cyc);
        model_wr(1, 32'h1234_5678, 4'hF);
        checks++;
        if (cyc !== 1 || pready !== 1'b0) begin
            failures++;
            $display("FAIL zw_write_timing: got cyc=%0d rdy=%b want 1/0", cyc, pready);
        end
        exp_q.push_back('{data: 32'h1234_5678, err: 1'b0, chk: 1'b1});
        apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, cyc);
        checks++;
        if (cyc !== 1 || pready !== 1'b0) begin
            failures++;
            $display("FAIL zw_read_timing: got cyc=%0d rdy=%b want 1/0", cyc, pready);
        end
        idle(1);
        checks++;
        if (reg_at(1) !== mem[1]) begin
            failures++;
            $display("FAIL zw_regs_q: got %h want %h", reg_at(1), mem[1]);
        end
        while (exp_q.size() > 0) begin
            resp_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL zw_resp: got none want %h/%b", e.data, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || (e.chk && o.data !== e.data)) begin
                    failures++;
                    $display("FAIL zw_resp: got %h/%b want %h/%b",
                             o.data, o.err, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_wait_strobe;
        int cyc;
        wait_cfg = 4'd3;
        exp_q.push_back('{data: 32'h0, err: 1'b0, chk: 1'b0});
        apb_xfer(8'h08, 1'b1, 32'hFFFF_FFFF, 4'b0101, cyc);
        model_wr(2, 32'hFFFF_FFFF, 4'b0101);
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL ws_latency: got %0d want 4", cyc);
        end
        wait_cfg = 4'd0;
        exp_q.push_back('{data: 32'h00FF_00FF, err: 1'b0, chk: 1'b1});
        apb_xfer(8'h08, 1'b0, 32'h0, 4'h0, cyc);
        wait_cfg = 4'd2;
        exp_q.push_back('{data: 32'h0, err: 1'b0, chk: 1'b0});
        apb_xfer(8'h08, 1'b1, 32'h1111_1111, 4'b0000, cyc);
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL ws_latency2: got %0d want 3", cyc);
        end
        idle(1);
        checks++;
        if (reg_at(2) !== mem[2]) begin
            failures++;
            $display("FAIL ws_regs_q: got %h want %h", reg_at(2), mem[2]);
        end
        while (exp_q.size() > 0) begin
            resp_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL ws_resp: got none want %h/%b", e.data, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || (e.chk && o.data !== e.data)) begin
                    failures++;
                    $display("FAIL ws_resp: got %h/%b want %h/%b",
                             o.data, o.err, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_errors;
        int cyc;
        wait_cfg = 4'd1;
        exp_q.push_back('{data: 32'h0, err: 1'b1, chk: 1'b1});
        apb_xfer(8'h00, 1'b1, 32'h5555_5555, 4'hF, cyc);
        exp_q.push_back('{data: 32'h0, err: 1'b1, chk: 1'b1});
        apb_xfer(8'h40, 1'b0, 32'h0, 4'h0, cyc);
        exp_q.push_back('{data: 32'h0, err: 1'b1, chk: 1'b1});
        apb_xfer(8'h06, 1'b1, 32'h7777_7777, 4'hF, cyc);
        wait_cfg = 4'd0;
        exp_q.push_back('{data: 32'h0, err: 1'b1, chk: 1'b1});
        apb_xfer(8'h05, 1'b0, 32'h0, 4'h0, cyc);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (reg_at(i) !== mem[i]) begin
                failures++;
                $display("FAIL err_reg%0d: got %h want %h", i, reg_at(i), mem[i]);
            end
        end
        while (exp_q.size() > 0) begin
            resp_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL err_resp: got none want %h/%b", e.data, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || (e.chk && o.data !== e.data)) begin
                    failures++;
                    $display("FAIL err_resp: got %h/%b want %h/%b",
                             o.data, o.err, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_proto;
        psel = 1'b1;
        penable = 1'b1;
        pwrite = 1'b1;
        paddr = 8'h0C;
        pwdata = 32'hAAAA_AAAA;
        pstrb = 4'hF;
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || pready !== 1'b0) begin
            failures++;
            $display("FAIL skip_setup: got perr=%b rdy=%b want 1/0", proto_err, pready);
        end
        idle(1);
        checks++;
        if (reg_at(3) !== 32'h0) begin
            failures++;
            $display("FAIL skip_setup_reg: got %h want 0", reg_at(3));
        end
        proto_clr = 1'b1;
        idle(1);
        proto_clr = 1'b0;
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL proto_clr: got %b want 0", proto_err);
        end
        wait_cfg = 4'd3;
        psel = 1'b1;
        paddr = 8'h0C;
        pwdata = 32'hBBBB_BBBB;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        penable = 1'b0;
        @(posedge clk);
        #1;
        psel = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || pready !== 1'b0 || pslverr !== 1'b0) begin
            failures++;
            $display("FAIL abort: got perr=%b rdy=%b err=%b want 1/0/0",
                     proto_err, pready, pslverr);
        end
        idle(5);
        checks++;
        if (reg_at(3) !== 32'h0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL abort_reg: got %h resp=%0d want 0/0", reg_at(3), obs_q.size());
        end
        proto_clr = 1'b1;
        psel = 1'b1;
        penable = 1'b1;
        idle(1);
        proto_clr = 1'b0;
        psel = 1'b0;
        penable = 1'b0;
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority: got %b want 0", proto_err);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        wait_cfg = 4'd3;
        psel = 1'b1;
        pwrite = 1'b1;
        paddr = 8'h10;
        pwdata = 32'h9999_9999;
        pstrb = 4'hF;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0 || reg_at(4) !== 32'h0) begin
            failures++;
            $display("FAIL rst_wait: got rdy=%b reg4=%h want 0/0", pready, reg_at(4));
        end
        psel = 1'b0;
        penable = 1'b0;
        for (int i = 1; i < 16; i++) mem[i] = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        wait_cfg = 4'd0;
        psel = 1'b1;
        pwrite = 1'b0;
        paddr = 8'h00;
        @(posedge clk);
        #1;
        checks++;
        if (pready !== 1'b1 || prdata !== ID) begin
            failures++;
            $display("FAIL rst_pre: got rdy=%b data=%h want 1/%h", pready, prdata, ID);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got rdy=%b data=%h err=%b want 0/0/0",
                     pready, prdata, pslverr);
        end
        psel = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        exp_q.push_back('{data: 32'h0, err: 1'b0, chk: 1'b1});
        apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, cyc);
        exp_q.push_back('{data: 32'h0, err: 1'b0, chk: 1'b0});
        apb_xfer(8'h04, 1'b1, 32'hCAFE_F00D, 4'hF, cyc);
        model_wr(1, 32'hCAFE_F00D, 4'hF);
        exp_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0, chk: 1'b1});
        apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, cyc);
        idle(1);
        checks++;
        if (reg_at(1) !== mem[1] || reg_at(4) !== 32'h0) begin
            failures++;
            $display("FAIL b2b_regs: got %h/%h want %h/0", reg_at(1), reg_at(4), mem[1]);
        end
        while (exp_q.size() > 0) begin
            resp_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_resp: got none want %h/%b", e.data, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || (e.chk && o.data !== e.data)) begin
                    failures++;
                    $display("FAIL b2b_resp: got %h/%b want %h/%b",
                             o.data, o.err, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_random;
        int cyc;
        int idx;
        int wc;
        logic [31:0] d;
        logic [3:0] s;
        for (int n = 0; n < 10; n++) begin
            idx = $urandom_range(1, 15);
            wc = $urandom_range(0, 5);
            d = $urandom;
            s = 4'($urandom);
            wait_cfg = 4'(wc);
            exp_q.push_back('{data: 32'h0, err: 1'b0, chk: 1'b0});
            apb_xfer(8'(idx * 4), 1'b1, d, s, cyc);
            model_wr(idx, d, s);
            checks++;
            if (cyc !== wc + 1) begin
                failures++;
                $display("FAIL rnd_latency: got %0d want %0d", cyc, wc + 1);
            end
            exp_q.push_back('{data: mem[idx], err: 1'b0, chk: 1'b1});
            apb_xfer(8'(idx * 4), 1'b0, 32'h0, 4'h0, cyc);
        end
        idle(1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (reg_at(i) !== mem[i]) begin
                failures++;
                $display("FAIL rnd_reg%0d: got %h want %h", i, reg_at(i), mem[i]);
            end
        end
        while (exp_q.size() > 0) begin
            resp_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL rnd_resp: got none want %h/%b", e.data, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || (e.chk && o.data !== e.data)) begin
                    failures++;
                    $display("FAIL rnd_resp: got %h/%b want %h/%b",
                             o.data, o.err, e.data, e.err);
                end
            end
        end
    endtask

    initial begin
        mem[0] = ID;
        for (int i = 1; i < 16; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);
        test_reset();
        test_zero_wait();
        test_wait_strobe();
        test_errors();
        test_proto();
        test_reset_mid();
        test_random();
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL stray_resp: got %0d extra want 0", obs_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
